// File: rtl/q_tile_reader_if.sv
// Bundle between q_tile_reader and its neighbours: run control, SRAM read port
// and the tile valid/ready stream.
interface q_tile_reader_if #(
  parameter int NUM_TILES = 32,
  parameter int WORD_W    = 128,
  parameter int ADDR_W    = 7
);
  localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [WORD_W-1:0]     MEM_DOUT;
  logic                  MEM_CEB;
  logic                  MEM_WEN;
  logic [ADDR_W-1:0]     MEM_ADDR;
  logic                  tile_valid;
  logic                  tile_ready;
  logic [4*WORD_W-1:0]   tile_data;
  logic [IDX_W-1:0]      tile_idx;
  logic                  tile_last;

  modport master (
    input  start, MEM_DOUT, tile_ready,
    output busy, done, MEM_CEB, MEM_WEN, MEM_ADDR,
           tile_valid, tile_data, tile_idx, tile_last
  );

  modport slave (
    output start, MEM_DOUT, tile_ready,
    input  busy, done, MEM_CEB, MEM_WEN, MEM_ADDR,
           tile_valid, tile_data, tile_idx, tile_last
  );
endinterface

// File: rtl/q_tile_reader.sv
// Streams NUM_TILES 4x4 FP32 tiles out of a 1-cycle-latency SRAM: four word
// reads per tile, one drain cycle, then a valid/ready presentation.
module q_tile_reader #(
  parameter int NUM_TILES = 32,
  parameter int WORD_W    = 128,
  parameter int ADDR_W    = 7
) (
  input  logic          clk,
  input  logic          rst,
  q_tile_reader_if.master bus
);
  localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       tile_idx_q, tile_idx_d;
  logic [1:0]             word_cnt_q, word_cnt_d;
  logic                   done_q, done_d;
  logic [3:0][WORD_W-1:0] data_q;
  logic                   cap_en;
  logic [1:0]             cap_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tile_idx_q <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_idx_q <= tile_idx_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tile_idx_d = tile_idx_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d    = FETCH;
        tile_idx_d = '0;
        word_cnt_d = '0;
      end
      FETCH: begin
        word_cnt_d = word_cnt_q + 2'd1;
        if (word_cnt_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: state_d = PRESENT;
      PRESENT: if (bus.tile_ready) begin
        word_cnt_d = '0;
        if (tile_idx_q == LAST_IDX) begin
          state_d    = IDLE;
          tile_idx_d = '0;
          done_d     = 1'b1;
        end else begin
          state_d    = FETCH;
          tile_idx_d = tile_idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data for the word issued last cycle lands now; word_cnt has already moved
  // on by one (and wrapped to 0 in DRAIN), so word_cnt-1 names the slice.
  assign cap_en = ((state_q == FETCH) && (word_cnt_q != 2'd0)) || (state_q == DRAIN);
  assign cap_k  = word_cnt_q - 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_q <= '0;
    else if (cap_en) data_q[cap_k] <= bus.MEM_DOUT;
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.MEM_CEB    = (state_q != FETCH);
  assign bus.MEM_WEN    = 1'b1;
  assign bus.MEM_ADDR   = (state_q == FETCH) ? ADDR_W'({tile_idx_q, word_cnt_q}) : '0;
  assign bus.tile_valid = (state_q == PRESENT);
  assign bus.tile_data  = data_q;
  assign bus.tile_idx   = tile_idx_q;
  assign bus.tile_last  = (state_q == PRESENT) && (tile_idx_q == LAST_IDX);
endmodule

// File: tb/tb_q_tile_reader.sv
// Randomized scoreboard bench for q_tile_reader: an SRAM model, an expected
// address/tile queue and a negedge monitor, plus a one-tile instance.
module tb_q_tile_reader;
  localparam int NT = 32;
  localparam int WW = 128;
  localparam int AW = 7;

  typedef struct {
    int            idx;
    logic [4*WW-1:0] data;
    bit            last;
  } tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  q_tile_reader_if #(.NUM_TILES(NT), .WORD_W(WW), .ADDR_W(AW)) u ();
  q_tile_reader_if #(.NUM_TILES(1),  .WORD_W(WW), .ADDR_W(AW)) u1 ();

  q_tile_reader #(.NUM_TILES(NT), .WORD_W(WW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(u));
  q_tile_reader #(.NUM_TILES(1),  .WORD_W(WW), .ADDR_W(AW)) dut1 (.clk(clk), .rst(rst), .bus(u1));

  logic [WW-1:0] mem [0:4*NT-1];
  tile_t exp_tiles[$];
  int    exp_addr[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    rand_ready = 1'b0;
  bit    bp_hold = 1'b0;

  task automatic chk(input string nm, input logic [4*WW-1:0] act, input logic [4*WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // SRAM: read issued in cycle t is visible during cycle t+1; junk otherwise.
  always @(posedge clk) begin
    u.MEM_DOUT  <= !u.MEM_CEB  ? mem[u.MEM_ADDR]  : garbage();
    u1.MEM_DOUT <= !u1.MEM_CEB ? mem[u1.MEM_ADDR] : garbage();
  end

  initial begin : ready_drv
    u.tile_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_hold)         u.tile_ready = 1'b0;
      else if (rand_ready) u.tile_ready = ($urandom_range(0, 3) != 0);
      else                 u.tile_ready = 1'b1;
    end
  end

  task automatic push_run();
    tile_t t;
    for (int j = 0; j < NT; j++) begin
      t.idx  = j;
      t.data = {mem[4*j+3], mem[4*j+2], mem[4*j+1], mem[4*j]};
      t.last = (j == NT - 1);
      exp_tiles.push_back(t);
    end
    for (int a = 0; a < 4 * NT; a++) exp_addr.push_back(a);
  endtask

  // Monitor: address order, tile contents/stability, stall behaviour, done.
  initial begin : mon
    tile_t cur;
    bit    have_cur = 0;
    bit    exp_done = 0;
    bit    gap_act = 0;
    int    gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_tiles.delete();
        exp_addr.delete();
        have_cur = 0; exp_done = 0; gap_act = 0;
        continue;
      end
      if (u.done || exp_done) chk("done_pulse", u.done, exp_done);
      chk("mem_wen", u.MEM_WEN, 1'b1);
      if (!u.MEM_CEB) begin
        chk("read_expected", exp_addr.size() != 0, 1'b1);
        if (exp_addr.size() != 0) chk("mem_addr", u.MEM_ADDR, exp_addr.pop_front());
      end
      if (gap_act) begin
        gap++;
        if (gap == 1) chk("fetch_after_hs", u.MEM_CEB, 1'b0);
        if (u.tile_valid) begin
          chk("hs_latency", gap, 6);
          gap_act = 0;
        end
      end
      exp_done = 0;
      if (u.tile_valid) begin
        chk("ceb_while_valid", u.MEM_CEB, 1'b1);
        if (!have_cur) begin
          chk("tile_expected", exp_tiles.size() != 0, 1'b1);
          if (exp_tiles.size() != 0) begin
            cur = exp_tiles.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          chk("tile_idx", u.tile_idx, cur.idx);
          chk("tile_data", u.tile_data, cur.data);
          chk("tile_last", u.tile_last, cur.last);
          if (u.tile_ready) begin
            have_cur = 0;
            exp_done = cur.last;
            if (!cur.last) begin gap_act = 1; gap = 0; end
          end
        end
      end else begin
        chk("tile_last_idle", u.tile_last, 1'b0);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  u.busy, 1'b0);
    chk({tag, "_done"},  u.done, 1'b0);
    chk({tag, "_ceb"},   u.MEM_CEB, 1'b1);
    chk({tag, "_wen"},   u.MEM_WEN, 1'b1);
    chk({tag, "_addr"},  u.MEM_ADDR, 0);
    chk({tag, "_valid"}, u.tile_valid, 1'b0);
    chk({tag, "_idx"},   u.tile_idx, 0);
    chk({tag, "_data"},  u.tile_data, 0);
    chk({tag, "_last"},  u.tile_last, 1'b0);
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    push_run();
    u.start = 1'b1;
    @(posedge clk); #1;
    u.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (u.done) begin ok = 1; break; end
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic wait_fetch(input int idx, input bit drain, input string nm);
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (u.busy && u.tile_idx == idx && !u.tile_valid && (u.MEM_CEB == drain)) begin ok = 1; break; end
    end
    chk(nm, ok, 1'b1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin : main
    int  cnt;
    bit  ok;
    u.start = 1'b0; u1.start = 1'b0; u1.tile_ready = 1'b1;
    for (int i = 0; i < 4 * NT; i++) mem[i] = garbage();

    repeat (3) @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_no_start", u.busy, 1'b0);

    // Run A: random ready, stray start in tile 3, 10+ cycle stall on tile 5.
    rand_ready = 1;
    do_start();
    cnt = 1; ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u.tile_valid) begin ok = 1; break; end
      cnt++;
    end
    chk("first_valid_seen", ok, 1'b1);
    chk("start_latency", cnt, 6);
    wait_fetch(3, 1'b0, "reach_tile3");
    u.start = 1'b1;
    @(negedge clk);
    u.start = 1'b0;
    wait_fetch(5, 1'b0, "reach_tile5");
    bp_hold = 1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u.tile_valid) begin ok = 1; break; end
    end
    chk("tile5_valid", ok, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("stall_hold", u.tile_valid, 1'b1);
    end
    bp_hold = 0;
    wait_done("runA_done");

    // Run B: ready tied high, then restart in the done cycle (run C).
    rand_ready = 0;
    do_start();
    wait_done("runB_done");
    push_run();
    u.start = 1'b1;
    @(posedge clk); #1 u.start = 1'b0;
    @(negedge clk);
    chk("restart_ceb", u.MEM_CEB, 1'b0);
    chk("restart_addr", u.MEM_ADDR, 0);
    wait_done("runC_done");

    // Run D: reset lands in DRAIN of tile 10.
    do_start();
    wait_fetch(10, 1'b1, "reach_drain10");
    rst = 1'b1;
    #1 chk_reset("abort");
    @(negedge clk);
    @(negedge clk);
    chk_reset("abort_hold");
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", u.busy, 1'b0);

    // Run E: fresh run after abort, random ready again.
    rand_ready = 1;
    do_start();
    @(negedge clk);
    chk("rerun_addr0", u.MEM_ADDR, 0);
    wait_done("runE_done");
    repeat (3) @(negedge clk);
    chk("tiles_left", exp_tiles.size(), 0);
    chk("addrs_left", exp_addr.size(), 0);

    // Single-tile instance: addresses 0..3, tile in cycle 6, done after.
    @(posedge clk); #1 u1.start = 1'b1;
    @(posedge clk); #1 u1.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("one_ceb", u1.MEM_CEB, 1'b0);
      chk("one_addr", u1.MEM_ADDR, k);
    end
    @(negedge clk);
    chk("one_drain_valid", u1.tile_valid, 1'b0);
    @(negedge clk);
    chk("one_valid", u1.tile_valid, 1'b1);
    chk("one_data", u1.tile_data, {mem[3], mem[2], mem[1], mem[0]});
    chk("one_last", u1.tile_last, 1'b1);
    chk("one_done_early", u1.done, 1'b0);
    @(negedge clk);
    chk("one_done", u1.done, 1'b1);
    chk("one_busy", u1.busy, 1'b0);
    @(negedge clk);
    chk("one_done_clear", u1.done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
